keypad_debounce: RTL and testbench

Front-end conditioning stage for the two-button binary code entry path. It takes raw, bouncy, asynchronous push-button levels and produces clean, mutually exclusive, debounced levels. Its output drives the keypad[1:0] input of the keycode shift-register encoder directly. The output is guaranteed one-hot or zero, returns to zero between presses, and never glitches, so each physical press yields exactly one rising edge downstream.

---
 rtl/keypad_pkg.sv | 6 +
 rtl/sync_2ff.sv | 19 +
 rtl/keypad_debounce.sv | 100 ++++++++++
 tb/tb_keypad_debounce.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad FSM states and default sizing
package keypad_pkg;
  localparam int NUM_KEYS_DEFAULT = 2;
  localparam int DEBOUNCE_DEFAULT = 10000;
  typedef enum logic [2:0] {IDLE, QUAL, HELD, REL, WAIT_LOW} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous clear
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/keypad_debounce.sv
// keypad_debounce: debounces raw buttons into a one-hot-or-zero keypad level
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NUM_KEYS-1:0] btn_raw,
  output logic [NUM_KEYS-1:0] keypad,
  output logic                conflict,
  output logic                busy
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  state_t              state, state_n;
  logic [NUM_KEYS-1:0] btn_s, owner, owner_n, keypad_n;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
  logic                conflict_n, any, multi, done;
  sync_2ff #(.W(NUM_KEYS)) u_sync (.clk(clk), .nrst(nrst), .d(btn_raw), .q(btn_s));
  assign any     = |btn_s;
  assign multi   = |(btn_s & (btn_s - NUM_KEYS'(1)));
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign done    = cnt_inc == CNT_MAX;
  assign busy    = state != IDLE;
  // keypad is its own register so it only ever moves 0->owner or owner->0
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    cnt_n      = cnt;
    keypad_n   = keypad;
    conflict_n = 1'b0;
    case (state)
      IDLE: begin
        if (multi) begin
          state_n    = WAIT_LOW;
          cnt_n      = '0;
          conflict_n = 1'b1;
        end else if (any) begin
          state_n = QUAL;
          owner_n = btn_s;
          cnt_n   = CNT_W'(1);
        end
      end
      QUAL: begin
        if (multi) begin
          state_n    = WAIT_LOW;
          cnt_n      = '0;
          conflict_n = 1'b1;
        end else if (!any) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (btn_s != owner) begin
          owner_n = btn_s;
          cnt_n   = CNT_W'(1);
        end else if (done) begin
          state_n  = HELD;
          cnt_n    = '0;
          keypad_n = owner;
        end else cnt_n = cnt_inc;
      end
      HELD: begin
        if (~|(btn_s & owner)) begin
          state_n = REL;
          cnt_n   = CNT_W'(1);
        end
      end
      REL: begin
        if (|(btn_s & owner)) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (done) begin
          state_n  = any ? WAIT_LOW : IDLE;
          cnt_n    = '0;
          keypad_n = '0;
        end else cnt_n = cnt_inc;
      end
      WAIT_LOW: begin
        cnt_n   = any ? '0 : (done ? '0 : cnt_inc);
        state_n = (!any && done) ? IDLE : WAIT_LOW;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state    <= IDLE;
      owner    <= '0;
      cnt      <= '0;
      keypad   <= '0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      cnt      <= cnt_n;
      keypad   <= keypad_n;
      conflict <= conflict_n;
    end
endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce: directed tables, corner sequences and a random run against a sample-history model
module tb_keypad_debounce;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] keypad;
  logic       conflict, busy;
  int         n_chk = 0, n_fail = 0;

  keypad_debounce #(.NUM_KEYS(2), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .nrst(nrst), .btn_raw(btn_raw),
    .keypad(keypad), .conflict(conflict), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Reference: phases (open / held / locked out) judged from run lengths of synced samples
  localparam int OPEN = 0, HOLD = 1, LOCK = 2;
  logic [1:0] hist[$];
  logic [1:0] r1 = 2'b00, r2 = 2'b00, s = 2'b00, m_key = 2'b00;
  logic       m_conf = 1'b0, m_busy = 1'b0;
  int         ph = OPEN;

  function automatic int run_of(input logic [1:0] mask, input logic [1:0] val);
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--)
      if ((hist[i] & mask) == val) n++;
      else break;
    return n;
  endfunction

  always @(posedge clk or negedge nrst)
    if (!nrst) begin
      r1 = 2'b00; r2 = 2'b00; m_key = 2'b00; m_conf = 1'b0; m_busy = 1'b0; ph = OPEN;
      hist.delete();
    end else begin
      s = r2; r2 = r1; r1 = btn_raw; m_conf = 1'b0;
      hist.push_back(s);
      if (ph == OPEN) begin
        if ($countones(s) > 1) begin
          m_conf = 1'b1; ph = LOCK; hist.delete();
        end else if (s != 2'b00 && run_of(2'b11, s) >= D) begin
          m_key = s; ph = HOLD; hist.delete();
        end
      end else if (ph == HOLD) begin
        if (run_of(m_key, 2'b00) >= D) begin
          m_key = 2'b00; ph = (s != 2'b00) ? LOCK : OPEN; hist.delete();
        end
      end else if (run_of(2'b11, 2'b00) >= D) begin
        ph = OPEN; hist.delete();
      end
      m_busy = (ph != OPEN) || (s != 2'b00);
    end

  typedef struct {
    logic [1:0] btn;
    int         n;
    logic [1:0] key;
    logic       conf;
    logic       bsy;
  } vec_t;
  vec_t tbl[12];

  task automatic step(input logic [1:0] b, input int n);
    btn_raw = b;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tbl = '{
      '{2'b01, 5,  2'b00, 1'b0, 1'b1},
      '{2'b01, 1,  2'b01, 1'b0, 1'b1},
      '{2'b01, 14, 2'b01, 1'b0, 1'b1},
      '{2'b00, 5,  2'b01, 1'b0, 1'b1},
      '{2'b00, 1,  2'b00, 1'b0, 1'b0},
      '{2'b11, 2,  2'b00, 1'b0, 1'b0},
      '{2'b11, 1,  2'b00, 1'b1, 1'b1},
      '{2'b11, 1,  2'b00, 1'b0, 1'b1},
      '{2'b00, 5,  2'b00, 1'b0, 1'b1},
      '{2'b00, 1,  2'b00, 1'b0, 1'b0},
      '{2'b01, 6,  2'b01, 1'b0, 1'b1},
      '{2'b00, 6,  2'b00, 1'b0, 1'b0}
    };
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", {keypad, conflict, busy}, 4'b0000);
    nrst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].btn, tbl[i].n);
      chk($sformatf("table[%0d]", i), {keypad, conflict, busy}, {tbl[i].key, tbl[i].conf, tbl[i].bsy});
    end
    for (int i = 0; i < 12; i++) begin
      step((i % 4 < 2) ? 2'b10 : 2'b00, 1);
      chk("bounce_quiet", {1'b0, keypad, conflict}, 4'b0000);
    end
    step(2'b10, 5);
    chk("bounce_early", {2'b00, keypad}, 4'b0000);
    step(2'b10, 1);
    chk("bounce_settle", {2'b00, keypad}, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      step((i < 2) ? 2'b00 : 2'b10, 1);
      chk("glitch_hold", {1'b0, keypad, conflict}, 4'b0100);
    end
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 1);
      chk("overlap_ignore", {1'b0, keypad, conflict}, 4'b0100);
    end
    step(2'b01, 5);
    chk("overlap_rel_early", {2'b00, keypad}, 4'b0010);
    step(2'b01, 1);
    chk("overlap_rel", {keypad, conflict, busy}, 4'b0001);
    for (int i = 0; i < 20; i++) begin
      step(2'b01, 1);
      chk("overlap_lock", {keypad, conflict, busy}, 4'b0001);
    end
    step(2'b00, 5);
    chk("overlap_wait", {keypad, conflict, busy}, 4'b0001);
    step(2'b00, 1);
    chk("overlap_idle", {keypad, conflict, busy}, 4'b0000);
    step(2'b10, 6);
    chk("pre_reset_hold", {2'b00, keypad}, 4'b0010);
    nrst = 1'b0;
    #1;
    chk("reset_async", {1'b0, keypad, busy}, 4'b0000);
    nrst = 1'b1;
    step(2'b10, 5);
    chk("post_reset_early", {2'b00, keypad}, 4'b0000);
    step(2'b10, 1);
    chk("post_reset_press", {2'b00, keypad}, 4'b0010);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        nrst = 1'b0;
        #1;
        chk("rand_reset", {1'b0, keypad, busy}, 4'b0000);
        nrst = 1'b1;
      end
      btn_raw = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 9)) begin
        @(negedge clk);
        chk("rand_model", {keypad, conflict, busy}, {m_key, m_conf, m_busy});
        chk("rand_onehot0", {3'b000, $onehot0(keypad)}, 4'b0001);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
